// File: rtl/cv32e40p_apu_arbiter.sv
// cv32e40p_apu_arbiter: round-robin sharing of one FPU between NUM_CORES APU masters,
// with an in-order tag FIFO routing results back to the requesting core.
module cv32e40p_apu_arbiter #(
  parameter int NUM_CORES        = 2,
  parameter int DEPTH            = 4,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic [NUM_CORES-1:0]                             core_req_i,
  output logic [NUM_CORES-1:0]                             core_gnt_o,
  input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]    core_operands_i,
  input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]            core_op_i,
  input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]       core_flags_i,
  output logic [NUM_CORES-1:0]                             core_rvalid_o,
  output logic [31:0]                                      core_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                      core_rflags_o,
  output logic                                             fpu_req_o,
  input  logic                                             fpu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]                   fpu_operands_o,
  output logic [APU_WOP_CPU-1:0]                           fpu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                      fpu_flags_o,
  input  logic                                             fpu_rvalid_i,
  input  logic [31:0]                                      fpu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                      fpu_rflags_i,
  output logic [$clog2(DEPTH):0]                           outstanding_o,
  output logic                                             err_o
);
  localparam int RW = $clog2(NUM_CORES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [RW-1:0] rr_q, sel;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] tags_q [DEPTH];
  logic any_req, full, empty, push, pop;
  assign any_req = |core_req_i;
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign fpu_req_o = any_req & ~full;
  assign push    = fpu_req_o & fpu_gnt_i;
  assign pop     = fpu_rvalid_i & ~empty;
  // Descending scan so the last hit is the first requester at or after rr_q.
  always_comb begin
    int k;
    sel = rr_q;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      k = (int'(rr_q) + i) % NUM_CORES;
      if (core_req_i[k]) sel = RW'(k);
    end
  end
  assign fpu_operands_o = any_req ? core_operands_i[sel] : '0;
  assign fpu_op_o       = any_req ? core_op_i[sel] : '0;
  assign fpu_flags_o    = any_req ? core_flags_i[sel] : '0;
  assign core_gnt_o     = push ? NUM_CORES'(1) << sel : '0;
  assign core_rvalid_o  = pop ? NUM_CORES'(1) << tags_q[rd_q] : '0;
  assign core_result_o  = fpu_result_i;
  assign core_rflags_o  = fpu_rflags_i;
  assign outstanding_o  = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (push) begin
        rr_q <= (sel == RW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (fpu_rvalid_i && empty) err_o <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) if (push) tags_q[wr_q] <= sel;
endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// tb_cv32e40p_apu_arbiter: directed plus randomized checks of the APU arbiter
// against a queue-based model of grants, tag order and error flag.
module tb_cv32e40p_apu_arbiter;
  localparam int N = 2, DEPTH = 4, NARGS = 3, WOP = 6, NDS = 15, NUS = 5;
  logic clk = 0, rst_ni = 0;
  logic [N-1:0] req = '0, gnt_c, rvalid_c;
  logic [N-1:0][NARGS-1:0][31:0] oper = '0;
  logic [N-1:0][WOP-1:0] op = '0;
  logic [N-1:0][NDS-1:0] flg = '0;
  logic [31:0] result_c, fres = '0;
  logic [NUS-1:0] rflags_c, frfl = '0;
  logic freq, fgnt = 0, frvalid = 0, err;
  logic [NARGS-1:0][31:0] foper;
  logic [WOP-1:0] fop;
  logic [NDS-1:0] fflg;
  logic [$clog2(DEPTH):0] outst;
  int checks = 0, errors = 0;
  int q[$];
  int rr = 0, last_gnt = -1;
  bit m_err = 0;

  always #5 clk = ~clk;

  cv32e40p_apu_arbiter #(.NUM_CORES(N), .DEPTH(DEPTH), .APU_NARGS_CPU(NARGS),
    .APU_WOP_CPU(WOP), .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_req_i(req), .core_gnt_o(gnt_c),
    .core_operands_i(oper), .core_op_i(op), .core_flags_i(flg),
    .core_rvalid_o(rvalid_c), .core_result_o(result_c), .core_rflags_o(rflags_c),
    .fpu_req_o(freq), .fpu_gnt_i(fgnt), .fpu_operands_o(foper), .fpu_op_o(fop),
    .fpu_flags_o(fflg), .fpu_rvalid_i(frvalid), .fpu_result_i(fres),
    .fpu_rflags_i(frfl), .outstanding_o(outst), .err_o(err));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sel();
    for (int i = 0; i < N; i++) if (req[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // One clock: inputs are already applied at posedge+1; combinational checks
  // at the falling edge, registered checks just after the rising edge.
  task automatic cyc();
    int s;
    bit push, pop, spur, canreq;
    s = exp_sel();
    canreq = s >= 0 && q.size() < DEPTH;
    push = canreq && fgnt;
    pop = frvalid && q.size() > 0;
    spur = frvalid && q.size() == 0;
    #4;
    check("fpu_req", 128'(freq), 128'(canreq));
    check("core_gnt", 128'(gnt_c), push ? 128'(1) << s : 128'(0));
    check("core_rvalid", 128'(rvalid_c), pop ? 128'(1) << q[0] : 128'(0));
    check("fpu_op", 128'(fop), s >= 0 ? 128'(op[s]) : 128'(0));
    check("fpu_flags", 128'(fflg), s >= 0 ? 128'(flg[s]) : 128'(0));
    check("fpu_operands", 128'(foper), s >= 0 ? 128'(oper[s]) : 128'(0));
    check("core_result", 128'(result_c), 128'(fres));
    check("core_rflags", 128'(rflags_c), 128'(frfl));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(s);
      rr = (s + 1) % N;
    end
    if (spur) m_err = 1;
    last_gnt = push ? s : -1;
    #1;
    check("outstanding", 128'(outst), 128'(q.size()));
    check("err", 128'(err), 128'(m_err));
  endtask

  task automatic new_data(input int i);
    op[i] = WOP'($urandom);
    flg[i] = NDS'($urandom);
    for (int j = 0; j < NARGS; j++) oper[i][j] = $urandom;
  endtask

  task automatic drain();
    req = '0;
    fgnt = 0;
    while (q.size() > 0) begin
      frvalid = 1;
      fres = $urandom;
      frvalid = 1;
      cyc();
    end
    frvalid = 0;
  endtask

  // Asynchronous reset between clock edges; entered at posedge+1.
  task automatic async_reset();
    req = '0;
    fgnt = 0;
    frvalid = 0;
    #3 rst_ni = 0;
    #1;
    check("rst_outstanding", 128'(outst), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_fpu_req", 128'(freq), 128'(0));
    q.delete();
    rr = 0;
    m_err = 0;
    last_gnt = -1;
    #2 rst_ni = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("reset_outstanding", 128'(outst), 128'(0));
    check("reset_err", 128'(err), 128'(0));
    check("reset_gnt", 128'(gnt_c), 128'(0));
    check("reset_rvalid", 128'(rvalid_c), 128'(0));
    check("reset_fpu_req", 128'(freq), 128'(0));
    check("reset_fpu_op", 128'(fop), 128'(0));
    #10 rst_ni = 1;
    for (int i = 0; i < N; i++) new_data(i);
    @(posedge clk);
    #1;
    // Round-robin with constant grant until full.
    req = 2'b11;
    fgnt = 1;
    for (int i = 0; i < 5; i++) cyc();
    check("rr_full_outstanding", 128'(outst), 128'(4));
    drain();
    // Result routing: core1, core0, core1, then three results.
    fgnt = 1;
    req = 2'b10; cyc();
    req = 2'b01; cyc();
    req = 2'b10; cyc();
    req = '0;
    fgnt = 0;
    frvalid = 1;
    fres = 32'h11; cyc();
    fres = 32'h22; cyc();
    fres = 32'h33; cyc();
    frvalid = 0;
    check("routing_outstanding", 128'(outst), 128'(0));
    // Full with simultaneous pop: blocked that cycle, granted next.
    req = 2'b01;
    fgnt = 1;
    for (int i = 0; i < 4; i++) cyc();
    frvalid = 1;
    fres = 32'hAB;
    cyc();
    check("full_pop_count", 128'(outst), 128'(3));
    frvalid = 0;
    cyc();
    check("full_regrant_count", 128'(outst), 128'(4));
    drain();
    // Push and pop together at count 2, wrapping the pointers.
    req = 2'b11;
    fgnt = 1;
    cyc();
    cyc();
    frvalid = 1;
    for (int i = 0; i < 10; i++) begin
      fres = $urandom;
      cyc();
    end
    check("pushpop_count", 128'(outst), 128'(2));
    drain();
    // Spurious result sets a sticky error.
    frvalid = 1;
    cyc();
    frvalid = 0;
    req = 2'b11;
    fgnt = 1;
    cyc();
    cyc();
    drain();
    check("sticky_err", 128'(err), 128'(1));
    // Reset mid-operation with three in flight.
    req = 2'b11;
    fgnt = 1;
    for (int i = 0; i < 3; i++) cyc();
    check("pre_reset_outstanding", 128'(outst), 128'(3));
    async_reset();
    req = 2'b11;
    fgnt = 1;
    cyc();
    check("post_reset_first_gnt", 128'(q[0]), 128'(0));
    drain();
    frvalid = 1;
    cyc();
    frvalid = 0;
    async_reset();
    // Randomized traffic; cores hold request data until granted.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] || last_gnt == i) begin
          req[i] = 1'($urandom_range(0, 1));
          new_data(i);
        end
      fgnt = 1'($urandom_range(0, 3) != 0);
      frvalid = q.size() > 0 ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 49) == 0);
      fres = $urandom;
      frl_rand();
      cyc();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic frl_rand();
    frfl = NUS'($urandom);
  endtask
endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Shares one FPU (APU-interface slave, e.g. `cv32e40p_fp_wrapper`) between `NUM_CORES` CV32E40P APU masters in a cluster configuration with `FPU=1`. It sits between the cores' `apu_*` ports and a single FPU instance:
- arbitrates requests round-robin;
- records the requester of every granted operation in an in-order tag FIFO;
- routes each returning result to the originating core.

The FPU returns results strictly in grant order.

## Interface
Parameters:
- `NUM_CORES`, 2, number of APU masters (2..8)
- `DEPTH`, 4, maximum outstanding FPU operations (power of two, ≥2)
- `APU_NARGS_CPU`, 3, operands per request
- `APU_WOP_CPU`, 6, opcode width
- `APU_NDSFLAGS_CPU`, 15, downstream flag width
- `APU_NUSFLAGS_CPU`, 5, upstream flag width

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `core_req_i`  in  `NUM_CORES`  per-core APU request
- `core_gnt_o`  out  `NUM_CORES`  per-core grant
- `core_operands_i`  in  `NUM_CORES`×`APU_NARGS_CPU`×32  operands
- `core_op_i`  in  `NUM_CORES`×`APU_WOP_CPU`  opcodes
- `core_flags_i`  in  `NUM_CORES`×`APU_NDSFLAGS_CPU`  downstream flags
- `core_rvalid_o`  out  `NUM_CORES`  per-core result valid
- `core_result_o`  out  32  result, broadcast to all cores
- `core_rflags_o`  out  `APU_NUSFLAGS_CPU`  result flags, broadcast
- `fpu_req_o`  out  1  request to FPU
- `fpu_gnt_i`  in  1  FPU grant
- `fpu_operands_o`  out  `APU_NARGS_CPU`×32  selected operands
- `fpu_op_o`  out  `APU_WOP_CPU`  selected opcode
- `fpu_flags_o`  out  `APU_NDSFLAGS_CPU`  selected flags
- `fpu_rvalid_i`  in  1  FPU result valid (single-cycle pulse, no back-pressure)
- `fpu_result_i`  in  32  FPU result
- `fpu_rflags_i`  in  `APU_NUSFLAGS_CPU`  FPU result flags
- `outstanding_o`  out  `$clog2(DEPTH)+1`  operations in flight
- `err_o`  out  1  sticky protocol error

## Operation
- **Request protocol:** cores hold `req`, `op`, `operands` and `flags` stable until granted. The arbiter never grants a core whose `req` is low.
- **Round-robin pointer** `rr_q` (`$clog2(NUM_CORES)` bits):
  - `sel` is the first requesting core at or after `rr_q`, wrapping modulo `NUM_CORES`.
  - The mux drives `fpu_operands_o`, `fpu_op_o` and `fpu_flags_o` from `sel`. They are all-zero when no core requests.
- **Request/grant path:**
  - `fpu_req_o` = (|`core_req_i`) & !full.
  - `core_gnt_o[sel]` = `fpu_gnt_i` & `fpu_req_o`. All other grant bits are 0.
- **Handshake** (`fpu_req_o` & `fpu_gnt_i`):
  - push `sel` into the tag FIFO;
  - `rr_q` ← `sel`+1, wrapping at `NUM_CORES` (non-power-of-two safe).
- **No handshake:** `rr_q` holds.
- **Tag FIFO:**
  - `DEPTH` entries with read/write pointers and a count.
  - full = (count == `DEPTH`); empty = (count == 0).
- **Full:** `fpu_req_o` is forced to 0, even if a pop occurs in the same cycle. There is no combinational `fpu_rvalid_i`→`fpu_req_o` path.
- **Result return:** on `fpu_rvalid_i` with FIFO not empty:
  - pop the head tag `h`;
  - `core_rvalid_o[h]`=1 in that same cycle; all other bits 0.
- **Broadcast outputs:** `core_result_o` = `fpu_result_i` and `core_rflags_o` = `fpu_rflags_i`, always passed through.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.
- **Pointer wrap-around:** pointers wrap modulo `DEPTH`.
- **`fpu_rvalid_i` while empty:**
  - no pop and no `core_rvalid_o`;
  - `err_o` ← 1 and stays set until reset.
- **`outstanding_o`:** equals the registered count.
- **Reset (asynchronous, also mid-operation):**
  - FIFO pointers, count, `rr_q` and `err_o` all go to 0.
  - In-flight tags are discarded. A subsequent `fpu_rvalid_i` for a pre-reset operation sets `err_o`.

## Timing
- **Reset values:**
  - Registered: `outstanding_o`=0, `err_o`=0.
  - Combinational, with all inputs idle: `core_gnt_o`=0, `core_rvalid_o`=0, `fpu_req_o`=0, `fpu_*` mux outputs = 0.
- **Grant latency:** 0 cycles from `fpu_gnt_i` to `core_gnt_o` (combinational).
- **Result latency:** 0 cycles from `fpu_rvalid_i` to `core_rvalid_o` (combinational from the registered head tag).
- **Arbitration throughput:** `rr_q` updates on the clock edge of the handshake cycle, so a back-to-back grant to a different core is possible in the next cycle. Throughput is one grant per cycle while not full.
- **Count update:** the count changes on the edge after push/pop. Full therefore blocks from the cycle after the `DEPTH`-th grant.

## Test plan
- **Round-robin, 2 cores, `fpu_gnt_i`=1 constantly, both `core_req_i`=1:** grants alternate core0, core1, core0… starting at core0 after reset. `outstanding_o` rises 1, 2, 3, 4 and then `fpu_req_o`=0.
- **Result routing:** grant order core1, core0, core1, then 3 `fpu_rvalid_i` pulses with results 0x11, 0x22, 0x33. `core_rvalid_o` = 0b10, 0b01, 0b10 in order, `core_result_o` matches, `outstanding_o` ends at 0.
- **Full with simultaneous pop:** with count=4 and `fpu_rvalid_i`=1 while core0 requests, no grant occurs that cycle and count becomes 3. The grant happens the next cycle and count returns to 4.
- **Push+pop same cycle:** at count=2, a handshake coinciding with `fpu_rvalid_i` leaves count 2. The popped tag is the older one, and the pointers wrap correctly over 10 such cycles.
- **Spurious result:** `fpu_rvalid_i` while empty gives `core_rvalid_o`=0 and `err_o`=1, which stays 1 through further traffic until `rst_ni`=0.
- **Reset mid-operation:** with 3 outstanding, assert `rst_ni`=0 asynchronously between clock edges. `outstanding_o`=0 and `err_o`=0 immediately. After release, core0 is granted first.
